// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one command into an AW/W/B or AR/R
// exchange and holds the result on the RSP_* port until the requester takes it.
module axi4_lite_master #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic                    CMD_WRITE,
  input  logic [ADDRESS-1:0]      CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [DATA_WIDTH/8-1:0] CMD_WSTRB,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]              RSP_RESP,
  output logic                    RSP_WRITE,
  output logic                    BUSY,
  output logic [ADDRESS-1:0]      M_AWADDR,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  output logic [ADDRESS-1:0]      M_ARADDR,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RVALID,
  output logic                    M_RREADY
);

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    DONE
  } state_e;

  state_e                  state_q;
  logic                    aw_valid_q;
  logic                    w_valid_q;
  logic                    b_ready_q;
  logic                    ar_valid_q;
  logic                    r_ready_q;
  logic [ADDRESS-1:0]      aw_addr_q;
  logic [ADDRESS-1:0]      ar_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]              rsp_resp_q;
  logic                    rsp_write_q;

  // A write channel is finished once its VALID has dropped or is being accepted now.
  logic aw_done;
  logic w_done;
  assign aw_done = !aw_valid_q || M_AWREADY;
  assign w_done  = !w_valid_q  || M_WREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    // NOTE: every output register is reset here so the bus sees clean zeros the
    // instant ARESETN falls, not merely the control bits.
    if (!ARESETN) begin
      state_q     <= IDLE;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_addr_q   <= '0;
      ar_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      rsp_write_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads the
      // values registered at the start of this cycle regardless of statement order.
      unique case (state_q)
        IDLE: begin
          if (CMD_VALID) begin
            if (CMD_WRITE) begin
              state_q    <= WADDR;
              aw_addr_q  <= CMD_ADDR;
              w_data_q   <= CMD_WDATA;
              w_strb_q   <= CMD_WSTRB;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
            end else begin
              state_q    <= RADDR;
              ar_addr_q  <= CMD_ADDR;
              ar_valid_q <= 1'b1;
            end
          end
        end

        WADDR: begin
          if (aw_valid_q && M_AWREADY) aw_valid_q <= 1'b0;
          if (w_valid_q && M_WREADY)   w_valid_q  <= 1'b0;
          if (aw_done && w_done) begin
            state_q   <= WRESP;
            b_ready_q <= 1'b1;
          end
        end

        WRESP: begin
          if (M_BVALID) begin
            state_q     <= DONE;
            b_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= M_BRESP;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b1;
          end
        end

        RADDR: begin
          if (M_ARREADY) begin
            state_q    <= RDATA;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
          end
        end

        RDATA: begin
          if (M_RVALID) begin
            state_q     <= DONE;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= M_RRESP;
            rsp_rdata_q <= M_RDATA;
            rsp_write_q <= 1'b0;
          end
        end

        DONE: begin
          if (RSP_READY) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign CMD_READY = (state_q == IDLE);
  assign BUSY      = (state_q != IDLE);

  assign M_AWADDR  = aw_addr_q;
  assign M_AWVALID = aw_valid_q;
  assign M_WDATA   = w_data_q;
  assign M_WSTRB   = w_strb_q;
  assign M_WVALID  = w_valid_q;
  assign M_BREADY  = b_ready_q;
  assign M_ARADDR  = ar_addr_q;
  assign M_ARVALID = ar_valid_q;
  assign M_RREADY  = r_ready_q;

  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_RESP  = rsp_resp_q;
  assign RSP_WRITE = rsp_write_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: directed vector table against a small word-memory
// AXI4-Lite slave model, plus stall, backpressure, reset and spurious-response cases.
module tb_axi4_lite_master;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        CMD_VALID, CMD_READY, CMD_WRITE;
  logic [31:0] CMD_ADDR, CMD_WDATA;
  logic [3:0]  CMD_WSTRB;
  logic        RSP_VALID, RSP_READY, RSP_WRITE, BUSY;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_RESP;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
  logic [3:0]  M_WSTRB;
  logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
  logic [1:0]  M_BRESP, M_RRESP;
  logic        M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

  initial forever #5 ACLK = ~ACLK;

  axi4_lite_master #(.ADDRESS(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_RESP(RSP_RESP), .RSP_WRITE(RSP_WRITE), .BUSY(BUSY),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave configuration, written only by the main sequence.
  int   slv_aw_delay = 0;
  int   slv_w_delay  = 0;
  int   slv_ar_delay = 0;
  int   slv_b_delay  = 0;
  logic spur_b = 1'b0;
  logic spur_r = 1'b0;

  function automatic logic [1:0] decode(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 2'b10;
    if (a >= 32'h40)     return 2'b11;
    return 2'b00;
  endfunction

  // Slave model: drives its outputs on the falling edge, so a READY/VALID raised
  // here completes at the following rising edge.
  initial begin
    logic [31:0] mem [16];
    logic        aw_full, w_full, ar_full, b_act, b_done, r_act, r_done;
    int          aw_wait, w_wait, ar_wait, b_wait;
    logic [31:0] s_awaddr, s_wdata, s_araddr, r_data_v;
    logic [3:0]  s_wstrb;
    logic [1:0]  b_resp_v, r_resp_v;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    aw_full = 0; w_full = 0; ar_full = 0; b_act = 0; b_done = 0; r_act = 0; r_done = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0;
    s_awaddr = '0; s_wdata = '0; s_araddr = '0; r_data_v = '0; s_wstrb = '0;
    b_resp_v = '0; r_resp_v = '0;
    M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = '0;
    M_ARREADY = 0; M_RVALID = 0; M_RDATA = '0; M_RRESP = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        aw_full = 0; w_full = 0; ar_full = 0; b_act = 0; b_done = 0; r_act = 0; r_done = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0;
        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = '0;
        M_ARREADY = 0; M_RVALID = 0; M_RDATA = '0; M_RRESP = '0;
      end else begin
        if (b_done) begin
          b_act = 0; b_done = 0; aw_full = 0; w_full = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        end
        if (aw_full && w_full && !b_act) begin
          if (b_wait >= slv_b_delay) begin
            b_act = 1;
            b_resp_v = decode(s_awaddr);
            if (b_resp_v == 2'b00)
              for (int i = 0; i < 4; i++)
                if (s_wstrb[i]) mem[s_awaddr[5:2]][8*i +: 8] = s_wdata[8*i +: 8];
          end else b_wait++;
        end
        if (b_act && M_BREADY) b_done = 1;
        M_BVALID = b_act | spur_b;
        M_BRESP  = b_act ? b_resp_v : (spur_b ? 2'b10 : 2'b00);

        if (M_AWVALID && !aw_full) begin
          if (aw_wait >= slv_aw_delay) begin M_AWREADY = 1; aw_full = 1; s_awaddr = M_AWADDR; end
          else begin M_AWREADY = 0; aw_wait++; end
        end else M_AWREADY = 0;

        if (M_WVALID && !w_full) begin
          if (w_wait >= slv_w_delay) begin
            M_WREADY = 1; w_full = 1; s_wdata = M_WDATA; s_wstrb = M_WSTRB;
          end else begin M_WREADY = 0; w_wait++; end
        end else M_WREADY = 0;

        if (r_done) begin r_act = 0; r_done = 0; ar_full = 0; ar_wait = 0; end
        if (ar_full && !r_act) begin
          r_act = 1;
          r_resp_v = decode(s_araddr);
          r_data_v = (r_resp_v == 2'b00) ? mem[s_araddr[5:2]] : 32'h0;
        end
        if (r_act && M_RREADY) r_done = 1;
        M_RVALID = r_act | spur_r;
        M_RDATA  = r_act ? r_data_v : (spur_r ? 32'hBAD0BAD0 : 32'h0);
        M_RRESP  = r_act ? r_resp_v : 2'b00;

        if (M_ARVALID && !ar_full) begin
          if (ar_wait >= slv_ar_delay) begin M_ARREADY = 1; ar_full = 1; s_araddr = M_ARADDR; end
          else begin M_ARREADY = 0; ar_wait++; end
        end else M_ARREADY = 0;
      end
    end
  end

  // Passive monitor: running totals the main sequence takes deltas of.
  int          rsp_seen = 0, aw_hi = 0, w_hi = 0, aw_chg = 0, viol = 0;
  logic        aw_prev = 1'b0;
  logic [31:0] aw_addr_prev = '0;
  always @(negedge ACLK) begin
    if (RSP_VALID) rsp_seen++;
    if (M_AWVALID) begin
      aw_hi++;
      if (aw_prev && M_AWADDR != aw_addr_prev) aw_chg++;
    end
    aw_prev = M_AWVALID;
    aw_addr_prev = M_AWADDR;
    if (M_WVALID) w_hi++;
    if ((M_BREADY && M_RREADY) || (M_AWVALID && M_ARVALID)) viol++;
  end

  task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold,
                         output logic [1:0] resp, output logic [31:0] rdata, output logic rw,
                         output int lat, output logic stable, output logic idle_after);
    int n;
    n = 0;
    resp = '0; rdata = '0; rw = 1'b0; lat = -1; stable = 1'b1; idle_after = 1'b0;
    while (!CMD_READY && n < 50) begin @(negedge ACLK); n++; end
    if (!CMD_READY) begin check("cmd_ready_wait", 64'(CMD_READY), 64'd1); return; end
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = a; CMD_WDATA = d; CMD_WSTRB = s;
    @(negedge ACLK);
    // Scramble the command bus so only latched values can reach the slave.
    CMD_VALID = 1'b0; CMD_ADDR = ~a; CMD_WDATA = ~d; CMD_WSTRB = ~s;
    lat = 1;
    while (!RSP_VALID && lat < 100) begin @(negedge ACLK); lat++; end
    if (!RSP_VALID) begin check("rsp_wait", 64'(RSP_VALID), 64'd1); lat = -1; return; end
    resp = RSP_RESP; rdata = RSP_RDATA; rw = RSP_WRITE;
    repeat (hold) begin
      @(negedge ACLK);
      if (!RSP_VALID || RSP_RESP != resp || RSP_RDATA != rdata || RSP_WRITE != rw || CMD_READY)
        stable = 1'b0;
    end
    RSP_READY = 1'b1;
    @(negedge ACLK);
    RSP_READY = 1'b0;
    idle_after = CMD_READY && !BUSY && !RSP_VALID;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NVEC = 10;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit before TB_RESULT");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [NVEC];
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        rw, stable, idle_after;
    int          lat, base_a, base_w, base_c, base_r;

    vecs[0] = '{1'b1, 32'h08,  32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 32'h08,  32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h06,  32'h55555555, 4'hF, 2'b10, 32'h0};
    vecs[3] = '{1'b0, 32'h06,  32'h0,        4'h0, 2'b10, 32'h0};
    vecs[4] = '{1'b1, 32'h10,  32'h12345678, 4'h3, 2'b00, 32'h0};
    vecs[5] = '{1'b0, 32'h10,  32'h0,        4'h0, 2'b00, 32'h00005678};
    vecs[6] = '{1'b1, 32'h0C,  32'hAABBCCDD, 4'hC, 2'b00, 32'h0};
    vecs[7] = '{1'b0, 32'h0C,  32'h0,        4'h0, 2'b00, 32'hAABB0000};
    vecs[8] = '{1'b1, 32'h100, 32'h01010101, 4'hF, 2'b11, 32'h0};
    vecs[9] = '{1'b0, 32'h100, 32'h0,        4'h0, 2'b11, 32'h0};

    CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = '0; CMD_WDATA = '0; CMD_WSTRB = '0; RSP_READY = 0;
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    check("rst_ctrl", 64'({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, RSP_VALID, BUSY}), 64'h0);
    check("rst_rsp", 64'({RSP_RESP, RSP_WRITE, RSP_RDATA}), 64'h0);
    check("rst_addr", {M_AWADDR, M_ARADDR}, 64'h0);
    check("rst_wdata", 64'({M_WSTRB, M_WDATA}), 64'h0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("post_rst_cmd_ready", 64'(CMD_READY), 64'd1);

    for (int i = 0; i < NVEC; i++) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0,
              resp, rdata, rw, lat, stable, idle_after);
      check($sformatf("v%0d_resp", i), 64'(resp), 64'(vecs[i].exp_resp));
      check($sformatf("v%0d_rdata", i), 64'(rdata), 64'(vecs[i].exp_rdata));
      check($sformatf("v%0d_rsp_write", i), 64'(rw), 64'(vecs[i].wr));
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
      check($sformatf("v%0d_idle_after", i), 64'(idle_after), 64'd1);
    end

    // AW stalled five cycles while W is accepted at once.
    slv_aw_delay = 5;
    base_a = aw_hi; base_w = w_hi; base_c = aw_chg;
    run_txn(1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 0, resp, rdata, rw, lat, stable, idle_after);
    slv_aw_delay = 0;
    check("aw_stall_resp", 64'(resp), 64'd0);
    check("aw_stall_latency", 64'(lat), 64'd8);
    check("aw_stall_awvalid_cycles", 64'(aw_hi - base_a), 64'd6);
    check("aw_stall_wvalid_cycles", 64'(w_hi - base_w), 64'd1);
    check("aw_stall_addr_changes", 64'(aw_chg - base_c), 64'd0);

    // W stalled three cycles while AW is accepted at once.
    slv_w_delay = 3;
    base_a = aw_hi; base_w = w_hi;
    run_txn(1'b1, 32'h18, 32'h0BADF00D, 4'hF, 0, resp, rdata, rw, lat, stable, idle_after);
    slv_w_delay = 0;
    check("w_stall_resp", 64'(resp), 64'd0);
    check("w_stall_latency", 64'(lat), 64'd6);
    check("w_stall_awvalid_cycles", 64'(aw_hi - base_a), 64'd1);
    check("w_stall_wvalid_cycles", 64'(w_hi - base_w), 64'd4);

    // AR stalled two cycles; reads back the first stalled write.
    slv_ar_delay = 2;
    run_txn(1'b0, 32'h14, 32'h0, 4'h0, 0, resp, rdata, rw, lat, stable, idle_after);
    slv_ar_delay = 0;
    check("ar_stall_rdata", 64'(rdata), 64'hCAFEF00D);
    check("ar_stall_latency", 64'(lat), 64'd5);

    // Requester withholds RSP_READY for four cycles.
    run_txn(1'b0, 32'h08, 32'h0, 4'h0, 4, resp, rdata, rw, lat, stable, idle_after);
    check("hold_rdata", 64'(rdata), 64'hDEADBEEF);
    check("hold_stable", 64'(stable), 64'd1);
    check("hold_idle_after", 64'(idle_after), 64'd1);

    // Reset asserted while waiting in WRESP.
    slv_b_delay = 10;
    base_r = rsp_seen;
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h0C; CMD_WDATA = 32'h11223344; CMD_WSTRB = 4'hF;
    @(negedge ACLK);
    CMD_VALID = 1'b0;
    @(negedge ACLK);
    check("pre_rst_in_wresp", 64'({BUSY, M_BREADY}), 64'h3);
    #2 ARESETN = 1'b0;
    #1;
    check("async_rst_ctrl", 64'({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, RSP_VALID, BUSY}), 64'h0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    slv_b_delay = 0;
    @(negedge ACLK);
    check("rst_release_cmd_ready", 64'(CMD_READY), 64'd1);
    check("rst_no_response", 64'(rsp_seen - base_r), 64'd0);
    run_txn(1'b1, 32'h0C, 32'h01020304, 4'hF, 0, resp, rdata, rw, lat, stable, idle_after);
    check("post_rst_write_resp", 64'(resp), 64'd0);
    check("post_rst_write_flag", 64'(rw), 64'd1);

    // Spurious B and R responses while idle.
    base_r = rsp_seen;
    spur_b = 1'b1; spur_r = 1'b1;
    repeat (3) @(negedge ACLK);
    check("spurious_busy_during", 64'({BUSY, CMD_READY}), 64'h1);
    spur_b = 1'b0; spur_r = 1'b0;
    repeat (2) @(negedge ACLK);
    check("spurious_state_after", 64'({BUSY, CMD_READY, M_BREADY, M_RREADY}), 64'h4);
    check("spurious_no_response", 64'(rsp_seen - base_r), 64'd0);

    check("ready_valid_exclusion", 64'(viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
